iq_byte_streamer: RTL
=====================

Name: iq_byte_streamer

Overview:
Downstream consumer of the I/Q sample FIFO read port, in the FIFO read-clock domain. Pops 32-bit complex words ({I[15:0], Q[15:0]}) and serializes each into four bytes on a valid/ready byte stream toward the host SMI interface. Only whole words are emitted. The block owns the FIFO read-enable and uses the FIFO empty flag.

Parameters:
DATA_WIDTH, 16, width of one I or Q component; word width is 2*DATA_WIDTH (only 16 is supported).
FRAME_WORDS, 256, data words per frame; used only with IQ_FRAME_HDR_EN.
HDR_MAGIC, 16'hCAFE, upper 16 bits of the frame header word; used only with IQ_FRAME_HDR_EN.

Ports:
clk_i  input  1  clock; same clock as the FIFO read side.
rst_i  input  1  reset; synchronous, active-high.
enable_i  input  1  streaming enable.
fifo_empty_i  input  1  FIFO empty flag.
fifo_rd_en_o  output  1  FIFO read enable; the FIFO returns data one cycle later.
fifo_data_i  input  2*DATA_WIDTH  FIFO read data, {I,Q}.
byte_o  output  8  output byte.
byte_valid_o  output  1  byte_o is valid.
byte_ready_i  input  1  sink accepts a byte.
byte_last_o  output  1  marks the final byte of a 4-byte unit.
word_count_o  output  16  count of data words fully sent.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - State goes to IDLE.
  - fifo_rd_en_o=0, byte_valid_o=0, byte_last_o=0, byte_o=8'h00, word_count_o=0.
  - Shift register and byte index clear; any partial word is discarded.
  - Reset mid-word takes effect on the next edge; no further bytes of that word are emitted.
- All outputs are registered.
- State machine:
  - IDLE: if enable_i=1 and fifo_empty_i=0, go to FETCH; otherwise stay.
  - FETCH: fifo_rd_en_o=1 for exactly this one cycle; next state is LATCH.
  - LATCH: capture fifo_data_i into the shift register; go to SEND with byte index 0, byte_valid_o=1.
  - SEND: a transfer occurs on any cycle with byte_valid_o=1 and byte_ready_i=1.
    - byte_o order is MSB first: word[31:24], [23:16], [15:8], [7:0].
    - byte_last_o=1 only with the byte at index 3.
    - After the index-3 transfer, word_count_o increments.
    - Then go to FETCH if enable_i=1 and fifo_empty_i=0 (sampled that cycle); otherwise go to IDLE with byte_valid_o=0.
- Backpressure: while byte_valid_o=1 and byte_ready_i=0, byte_o, byte_last_o and byte_valid_o hold stable. Valid is never withdrawn before a transfer.
- Throughput with byte_ready_i held at 1: 6 cycles per word (FETCH, LATCH, then 4 SEND cycles).
- Latency: the first byte is valid 2 cycles after fifo_rd_en_o is asserted.
- enable_i is sampled only in IDLE and at a word boundary. Deasserting it mid-word completes the current word, then the block idles.
- fifo_empty_i is never sampled mid-word. No read is ever issued while fifo_empty_i=1.
- word_count_o wraps from 16'hFFFF to 16'h0000.

Optional Feature:
IQ_FRAME_HDR_EN:
- Defined:
  - A 4-byte header unit {HDR_MAGIC, frame_idx[15:0]} is emitted before the first data word after reset, and after every FRAME_WORDS data words.
  - frame_idx starts at 0 on reset, increments per header, and wraps at 16'hFFFF.
  - The header uses state HDR, entered from IDLE or from a word boundary, under the same fetch conditions.
  - The header is sent before FETCH for the next word, so the FIFO read happens only after the header's last byte transfers.
  - byte_last_o=1 on header byte 3. Headers do not increment word_count_o.
- Not defined: no HDR state or frame logic; FRAME_WORDS and HDR_MAGIC are unused.

Test Plan:
1. Reset: hold rst_i=1 for 2 cycles with enable_i=1 -> fifo_rd_en_o=0, byte_valid_o=0, byte_o=8'h00, word_count_o=0.
2. Single word: FIFO holds 32'h11223344, byte_ready_i=1, enable_i=1 -> one-cycle fifo_rd_en_o; bytes 11,22,33,44 on consecutive cycles starting 2 cycles later; byte_last_o only with 44; word_count_o=1; returns to IDLE when the FIFO is empty.
3. Backpressure: drop byte_ready_i for 3 cycles while byte_o=8'h22 is valid -> 8'h22 and byte_valid_o held stable for all 3 cycles; 33 follows on the cycle after ready returns.
4. Empty: enable_i=1, fifo_empty_i=1 for 20 cycles -> fifo_rd_en_o never asserted, byte_valid_o stays 0.
5. Enable drop mid-word: deassert enable_i after byte 1 of 32'hA1B2C3D4 with a second word queued -> C3, D4 still sent, no second fifo_rd_en_o, word_count_o=1.
6. With IQ_FRAME_HDR_EN, FRAME_WORDS=2, 4 words queued -> CA FE 00 00, word0, word1, CA FE 00 01, word2, word3; word_count_o=4.

Source files
------------

// File: rtl/iq_byte_streamer_if.sv
// Bundles the FIFO read port and the byte stream seen by iq_byte_streamer.
// master: the streamer side; slave: the FIFO/sink environment side.
interface iq_byte_streamer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      enable_i;
    logic                      fifo_empty_i;
    logic                      fifo_rd_en_o;
    logic [2*DATA_WIDTH-1:0]   fifo_data_i;
    logic [7:0]                byte_o;
    logic                      byte_valid_o;
    logic                      byte_ready_i;
    logic                      byte_last_o;
    logic [15:0]               word_count_o;

    modport master (
        input  enable_i, fifo_empty_i, fifo_data_i, byte_ready_i,
        output fifo_rd_en_o, byte_o, byte_valid_o, byte_last_o, word_count_o
    );

    modport slave (
        output enable_i, fifo_empty_i, fifo_data_i, byte_ready_i,
        input  fifo_rd_en_o, byte_o, byte_valid_o, byte_last_o, word_count_o
    );
endinterface

// File: rtl/iq_byte_streamer.sv
// Pops {I,Q} words from the sample FIFO and serializes each MSB-first onto a valid/ready
// byte stream. Define IQ_FRAME_HDR_EN to prefix every FRAME_WORDS words with a header unit.
module iq_byte_streamer #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          FRAME_WORDS = 256,
    parameter logic [15:0] HDR_MAGIC   = 16'hCAFE
) (
    input logic                clk_i,
    input logic                rst_i,
    iq_byte_streamer_if.master bus
);
    localparam int WORD_W = 2 * DATA_WIDTH;

    if (DATA_WIDTH != 16) begin : g_bad_width
        $error("iq_byte_streamer: only DATA_WIDTH=16 is supported");
    end
    if (FRAME_WORDS < 1 || FRAME_WORDS > 65536 || $bits(HDR_MAGIC) != 16) begin : g_bad_frame
        $error("iq_byte_streamer: FRAME_WORDS must be 1..65536");
    end

`ifdef IQ_FRAME_HDR_EN
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, HDR} state_t;
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_WORDS - 1);
    logic [15:0] frame_idx_q, frame_idx_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        need_hdr_q, need_hdr_d;
`else
    typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_t;
`endif

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [7:0]          byte_q, byte_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic                xfer, start, launch;

    assign xfer  = valid_q & bus.byte_ready_i;
    assign start = bus.enable_i & ~bus.fifo_empty_i;

    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        valid_d = valid_q;
        last_d  = last_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        launch  = 1'b0;
`ifdef IQ_FRAME_HDR_EN
        frame_idx_d = frame_idx_q;
        frame_cnt_d = frame_cnt_q;
        need_hdr_d  = need_hdr_q;
`endif
        case (state_q)
            IDLE:  launch = start;
            FETCH: state_d = LATCH;
            LATCH: begin
                shift_d = bus.fifo_data_i;
                byte_d  = bus.fifo_data_i[WORD_W-1 -: 8];
                valid_d = 1'b1;
                last_d  = 1'b0;
                idx_d   = 2'd0;
                state_d = SEND;
            end
`ifdef IQ_FRAME_HDR_EN
            SEND, HDR: begin
`else
            SEND: begin
`endif
                if (xfer) begin
                    if (idx_q != 2'd3) begin
                        shift_d = {shift_q[WORD_W-9:0], 8'h00};
                        byte_d  = shift_q[WORD_W-9 -: 8];
                        idx_d   = idx_q + 2'd1;
                        last_d  = (idx_q == 2'd2);
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = 2'd0;
                        state_d = IDLE;
`ifdef IQ_FRAME_HDR_EN
                        // A header is only launched with a non-empty FIFO, so the
                        // fetch that follows it does not re-check enable.
                        if (state_q == HDR) begin
                            frame_idx_d = frame_idx_q + 16'd1;
                            need_hdr_d  = 1'b0;
                            if (!bus.fifo_empty_i) begin
                                state_d = FETCH;
                                rd_en_d = 1'b1;
                            end
                        end else begin
                            wcnt_d = wcnt_q + 16'd1;
                            launch = start;
                            if (frame_cnt_q == FRAME_LAST) begin
                                frame_cnt_d = 16'd0;
                                need_hdr_d  = 1'b1;
                            end else begin
                                frame_cnt_d = frame_cnt_q + 16'd1;
                            end
                        end
`else
                        wcnt_d = wcnt_q + 16'd1;
                        launch = start;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
`ifdef IQ_FRAME_HDR_EN
            if (need_hdr_d) begin
                state_d = HDR;
                shift_d = {HDR_MAGIC, frame_idx_q};
                byte_d  = HDR_MAGIC[15:8];
                valid_d = 1'b1;
                last_d  = 1'b0;
                idx_d   = 2'd0;
            end else begin
                state_d = FETCH;
                rd_en_d = 1'b1;
            end
`else
            state_d = FETCH;
            rd_en_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            byte_q  <= 8'h00;
            shift_q <= '0;
            idx_q   <= 2'd0;
            wcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef IQ_FRAME_HDR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_idx_q <= 16'd0;
            frame_cnt_q <= 16'd0;
            need_hdr_q  <= 1'b1;
        end else begin
            frame_idx_q <= frame_idx_d;
            frame_cnt_q <= frame_cnt_d;
            need_hdr_q  <= need_hdr_d;
        end
    end
`endif

    assign bus.fifo_rd_en_o = rd_en_q;
    assign bus.byte_o       = byte_q;
    assign bus.byte_valid_o = valid_q;
    assign bus.byte_last_o  = last_q;
    assign bus.word_count_o = wcnt_q;
endmodule
